// File: rtl/water_flow_led_if.sv
// Control and LED-drive bundle for the water-flow LED sequencer.
// The sequencer is the slave side; the switch logic / board is the master.
interface water_flow_led_if #(
    parameter int LED_NUM = 8
);
    logic               en;
    logic               dir;
    logic               mode;
    logic               clr;
    logic [LED_NUM-1:0] led;
    logic               step_tick;
    logic               cycle_done;
    logic               running;

    modport master (
        output en, dir, mode, clr,
        input  led, step_tick, cycle_done, running
    );

    modport slave (
        input  en, dir, mode, clr,
        output led, step_tick, cycle_done, running
    );
endinterface

// File: rtl/water_flow_led.sv
// Running-light LED sequencer: walking dot or Johnson fill bar, advanced once
// every DIV cycles, with pause, reverse, mode switch and synchronous clear.
module water_flow_led #(
    parameter int LED_NUM = 8,
    parameter int DIV     = 50_000_000
) (
    input logic             clk,
    input logic             rst_n,
    water_flow_led_if.slave bus
);
    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_sync_meta;
    logic [2:0]         r_sync;
    logic               r_mode_q;
    logic [LED_NUM-1:0] r_led;
    logic [CW-1:0]      r_cnt;
    logic               r_step_tick;
    logic               r_cycle_done;

    logic               w_en_s;
    logic               w_dir_s;
    logic               w_mode_s;
    logic               w_mode_chg;
    logic [LED_NUM-1:0] w_start;
    logic [LED_NUM-1:0] w_adv;
    logic [LED_NUM-1:0] w_led_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_step_nxt;
    logic               w_done_nxt;

    function automatic logic [LED_NUM-1:0] f_start(input logic m, input logic d);
        logic [LED_NUM-1:0] v;
        v = '0;
        if (!m) begin
            if (d) v[LED_NUM-1] = 1'b1;
            else   v[0]         = 1'b1;
        end
        return v;
    endfunction

    // Johnson directions are exact inverses, so a dir flip reverses in place.
    function automatic logic [LED_NUM-1:0] f_advance(input logic [LED_NUM-1:0] v,
                                                     input logic m, input logic d);
        logic [LED_NUM-1:0] r;
        case ({m, d})
            2'b00:   r = {v[LED_NUM-2:0], v[LED_NUM-1]};
            2'b01:   r = {v[0], v[LED_NUM-1:1]};
            2'b10:   r = {v[LED_NUM-2:0], ~v[LED_NUM-1]};
            default: r = {~v[0], v[LED_NUM-1:1]};
        endcase
        return r;
    endfunction

    assign w_en_s     = r_sync[2];
    assign w_dir_s    = r_sync[1];
    assign w_mode_s   = r_sync[0];
    assign w_mode_chg = (w_mode_s != r_mode_q) && (r_state != IDLE);
    assign w_start    = f_start(w_mode_s, w_dir_s);
    assign w_adv      = f_advance(r_led, w_mode_s, w_dir_s);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = IDLE;
        end else if (!w_mode_chg) begin
            case (r_state)
                IDLE:    if (w_en_s)  w_state_nxt = RUN;
                RUN:     if (!w_en_s) w_state_nxt = PAUSE;
                PAUSE:   if (w_en_s)  w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The PAUSE->RUN edge already counts, so a held cnt resumes where it left off.
    always_comb begin
        w_led_nxt  = r_led;
        w_cnt_nxt  = r_cnt;
        w_step_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (bus.clr) begin
            w_led_nxt = '0;
            w_cnt_nxt = '0;
        end else if (w_mode_chg) begin
            w_led_nxt = w_start;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_led_nxt = w_en_s ? w_start : '0;
                    w_cnt_nxt = '0;
                end
                RUN, PAUSE: begin
                    if (w_en_s) begin
                        if (r_cnt == CNT_MAX) begin
                            w_led_nxt  = w_adv;
                            w_cnt_nxt  = '0;
                            w_step_nxt = 1'b1;
                            w_done_nxt = (w_adv == w_start);
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_led_nxt = '0;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta  <= '0;
            r_sync       <= '0;
            r_mode_q     <= 1'b0;
            r_led        <= '0;
            r_cnt        <= '0;
            r_step_tick  <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_sync_meta  <= {bus.en, bus.dir, bus.mode};
            r_sync       <= r_sync_meta;
            r_mode_q     <= w_mode_s;
            r_led        <= w_led_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step_tick  <= w_step_nxt;
            r_cycle_done <= w_done_nxt;
        end
    end

    assign bus.led        = r_led;
    assign bus.step_tick  = r_step_tick;
    assign bus.cycle_done = r_cycle_done;
    assign bus.running    = (r_state == RUN);
endmodule
